// File: rtl/vga_fb_pkg.sv
// Shared widths, limits and slot tags for the framebuffer arbiter.
package vga_fb_pkg;

  localparam int FB_ADDR_W       = 15;
  localparam int FB_DATA_W       = 12;
  localparam int FB_STARVE_LIMIT = 1024;

  typedef enum logic [1:0] {
    TAG_NONE    = 2'd0,
    TAG_DISP    = 2'd1,
    TAG_HOST_RD = 2'd2,
    TAG_HOST_WR = 2'd3
  } slot_tag_e;

endpackage

// File: rtl/fb_starve_wd.sv
// Host starvation watchdog: counts consecutive blocked host cycles, raises a sticky flag.
module fb_starve_wd #(
  parameter int LIMIT = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic host_valid_i,
  input  logic host_ready_i,
  input  logic starve_clr_i,
  output logic host_starve_o
);

  localparam int CNT_W = $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             blocked;

  assign blocked = host_valid_i & ~host_ready_i;

  always_comb begin
    cnt_next = '0;
    if (blocked) begin
      cnt_next = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    end
  end

  // Clear wins over a coincident set so the count restarts from zero.
  always_ff @(posedge clk_i) begin
    if (rst_i || starve_clr_i) begin
      cnt           <= '0;
      host_starve_o <= 1'b0;
    end else begin
      cnt <= cnt_next;
      if (cnt_next == CNT_MAX) begin
        host_starve_o <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: display fetches take strict priority over host access.
module vga_fb_arbiter
  import vga_fb_pkg::*;
#(
  parameter int ADDR_W       = FB_ADDR_W,
  parameter int DATA_W       = FB_DATA_W,
  parameter int STARVE_LIMIT = FB_STARVE_LIMIT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              disp_req_i,
  input  logic [ADDR_W-1:0] disp_addr_i,
  output logic              disp_valid_o,
  output logic [DATA_W-1:0] disp_data_o,
  input  logic              host_valid_i,
  output logic              host_ready_o,
  input  logic              host_we_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [DATA_W-1:0] host_wdata_i,
  output logic              host_rvalid_o,
  output logic [DATA_W-1:0] host_rdata_o,
  input  logic              blank_i,
  input  logic              cfg_blank_only_i,
  input  logic              starve_clr_i,
  output logic              host_starve_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  slot_tag_e next_tag;
  slot_tag_e tag_s1;
  slot_tag_e tag_s2;
  logic      host_xfer;

  assign host_ready_o = host_valid_i & ~disp_req_i & (~cfg_blank_only_i | blank_i) & ~rst_i;
  assign host_xfer    = host_valid_i & host_ready_o;

  always_comb begin
    next_tag = TAG_NONE;
    if (disp_req_i) begin
      next_tag = TAG_DISP;
    end else if (host_xfer) begin
      next_tag = host_we_i ? TAG_HOST_WR : TAG_HOST_RD;
    end
  end

  // tag_s1 rides with the RAM command, tag_s2 with the returning read data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_en_o      <= 1'b0;
      mem_we_o      <= 1'b0;
      mem_addr_o    <= '0;
      mem_wdata_o   <= '0;
      tag_s1        <= TAG_NONE;
      tag_s2        <= TAG_NONE;
      disp_valid_o  <= 1'b0;
      disp_data_o   <= '0;
      host_rvalid_o <= 1'b0;
      host_rdata_o  <= '0;
    end else begin
      mem_en_o <= (next_tag != TAG_NONE);
      mem_we_o <= (next_tag == TAG_HOST_WR);
      if (disp_req_i) begin
        mem_addr_o <= disp_addr_i;
      end else if (host_xfer) begin
        mem_addr_o  <= host_addr_i;
        mem_wdata_o <= host_wdata_i;
      end
      tag_s1        <= next_tag;
      tag_s2        <= tag_s1;
      disp_valid_o  <= (tag_s2 == TAG_DISP);
      host_rvalid_o <= (tag_s2 == TAG_HOST_RD);
      if (tag_s2 == TAG_DISP) begin
        disp_data_o <= mem_rdata_i;
      end
      if (tag_s2 == TAG_HOST_RD) begin
        host_rdata_o <= mem_rdata_i;
      end
    end
  end

  fb_starve_wd #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve_wd (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .host_valid_i (host_valid_i),
    .host_ready_i (host_ready_o),
    .starve_clr_i (starve_clr_i),
    .host_starve_o(host_starve_o)
  );

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed plus randomized bench for vga_fb_arbiter with a cycle-scheduled reference model.
module tb_vga_fb_arbiter;

  localparam int AW  = 15;
  localparam int DW  = 12;
  localparam int LIM = 1024;
  localparam int RAM_WORDS = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_i, disp_req_i, disp_valid_o;
  logic [AW-1:0] disp_addr_i;
  logic [DW-1:0] disp_data_o;
  logic          host_valid_i, host_ready_o, host_we_i, host_rvalid_o;
  logic [AW-1:0] host_addr_i;
  logic [DW-1:0] host_wdata_i, host_rdata_o;
  logic          blank_i, cfg_blank_only_i, starve_clr_i, host_starve_o;
  logic          mem_en_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o, mem_rdata_i;

  always #5 clk = ~clk;

  vga_fb_arbiter dut (
    .clk_i(clk), .rst_i(rst_i),
    .disp_req_i(disp_req_i), .disp_addr_i(disp_addr_i),
    .disp_valid_o(disp_valid_o), .disp_data_o(disp_data_o),
    .host_valid_i(host_valid_i), .host_ready_o(host_ready_o),
    .host_we_i(host_we_i), .host_addr_i(host_addr_i), .host_wdata_i(host_wdata_i),
    .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o),
    .blank_i(blank_i), .cfg_blank_only_i(cfg_blank_only_i),
    .starve_clr_i(starve_clr_i), .host_starve_o(host_starve_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  function automatic logic [DW-1:0] init_word(input int unsigned a);
    return DW'(a * 37 + 32'h5A3);
  endfunction

  // Synchronous RAM, one-cycle read latency, preloaded on the first edge.
  logic [DW-1:0] ram [RAM_WORDS];
  logic          ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < RAM_WORDS; i++) ram[i] <= init_word(i);
      ram_loaded <= 1'b1;
    end else if (mem_en_o) begin
      if (mem_we_o) ram[mem_addr_o] <= mem_wdata_o;
      else          mem_rdata_i <= ram[mem_addr_o];
    end
  end

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned cyc = 0;

  // Expected outputs scheduled by cycle (index = cycle mod 8).
  logic          m_en [8], m_we [8], m_dv [8], m_hv [8];
  logic [AW-1:0] m_addr [8];
  logic [DW-1:0] m_wd [8], m_dd [8], m_hd [8];
  logic [DW-1:0] shadow [RAM_WORDS];
  logic [DW-1:0] h_dd, h_hd;
  logic          armed, post_rst, s_flag;
  int unsigned   s_cnt;

  // Stimulus variables
  logic          d_rst, d_dreq, d_blank, d_bonly, d_clr;
  logic [AW-1:0] d_daddr;
  logic          h_pend, h_we;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_wd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic clear_slot(input int unsigned k);
    m_en[k] = 1'b0; m_we[k] = 1'b0; m_dv[k] = 1'b0; m_hv[k] = 1'b0;
    m_addr[k] = '0; m_wd[k] = '0; m_dd[k] = '0; m_hd[k] = '0;
  endtask

  task automatic step();
    int unsigned s, n1, n3;
    logic exp_ready;
    rst_i = d_rst; disp_req_i = d_dreq; disp_addr_i = d_daddr;
    host_valid_i = h_pend; host_we_i = h_we; host_addr_i = h_addr; host_wdata_i = h_wd;
    blank_i = d_blank; cfg_blank_only_i = d_bonly; starve_clr_i = d_clr;
    #1;
    s  = cyc % 8;
    n1 = (cyc + 1) % 8;
    n3 = (cyc + 3) % 8;
    exp_ready = h_pend & ~d_dreq & (~d_bonly | d_blank) & ~d_rst;
    if (armed) begin
      if (m_dv[s]) h_dd = m_dd[s];
      if (m_hv[s]) h_hd = m_hd[s];
      chk("host_ready", 32'(host_ready_o), 32'(exp_ready));
      chk("mem_en", 32'(mem_en_o), 32'(m_en[s]));
      chk("mem_we", 32'(mem_we_o), 32'(m_we[s]));
      if (m_en[s]) chk("mem_addr", 32'(mem_addr_o), 32'(m_addr[s]));
      if (m_we[s]) chk("mem_wdata", 32'(mem_wdata_o), 32'(m_wd[s]));
      chk("disp_valid", 32'(disp_valid_o), 32'(m_dv[s]));
      chk("disp_data", 32'(disp_data_o), 32'(h_dd));
      chk("host_rvalid", 32'(host_rvalid_o), 32'(m_hv[s]));
      chk("host_rdata", 32'(host_rdata_o), 32'(h_hd));
      chk("host_starve", 32'(host_starve_o), 32'(s_flag));
      if (post_rst) begin
        chk("rst_mem_addr", 32'(mem_addr_o), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata_o), 32'd0);
      end
    end
    clear_slot(s);
    if (d_rst) begin
      for (int k = 0; k < 8; k++) clear_slot(k);
      h_dd = '0; h_hd = '0; s_cnt = 0; s_flag = 1'b0;
      post_rst = 1'b1; armed = 1'b1;
    end else begin
      post_rst = 1'b0;
      if (d_dreq) begin
        m_en[n1] = 1'b1; m_addr[n1] = d_daddr;
        m_dv[n3] = 1'b1; m_dd[n3] = shadow[d_daddr];
      end else if (exp_ready) begin
        m_en[n1] = 1'b1; m_addr[n1] = h_addr;
        if (h_we) begin
          m_we[n1] = 1'b1; m_wd[n1] = h_wd; shadow[h_addr] = h_wd;
        end else begin
          m_hv[n3] = 1'b1; m_hd[n3] = shadow[h_addr];
        end
      end
      if (d_clr) begin
        s_cnt = 0; s_flag = 1'b0;
      end else begin
        if (h_pend && !exp_ready) s_cnt = (s_cnt + 1 > LIM) ? LIM : s_cnt + 1;
        else                      s_cnt = 0;
        if (s_cnt == LIM) s_flag = 1'b1;
      end
    end
    if (exp_ready) h_pend = 1'b0;
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic host_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    h_pend = 1'b1; h_we = we; h_addr = a; h_wd = d;
  endtask

  initial begin
    for (int i = 0; i < RAM_WORDS; i++) shadow[i] = init_word(i);
    for (int k = 0; k < 8; k++) clear_slot(k);
    armed = 1'b0; post_rst = 1'b0; s_flag = 1'b0; s_cnt = 0; h_dd = '0; h_hd = '0;
    d_rst = 1'b1; d_dreq = 1'b0; d_daddr = '0; d_blank = 1'b0; d_bonly = 1'b0; d_clr = 1'b0;
    h_pend = 1'b0; h_we = 1'b0; h_addr = '0; h_wd = '0;
    rst_i = 1'b1; disp_req_i = 1'b0; disp_addr_i = '0; host_valid_i = 1'b0; host_we_i = 1'b0;
    host_addr_i = '0; host_wdata_i = '0; blank_i = 1'b0; cfg_blank_only_i = 1'b0; starve_clr_i = 1'b0;
    @(posedge clk);
    #2;

    // Reset and idle
    step(); step();
    d_rst = 1'b0;
    step();

    // Preload 0xF0A at 0x0123, then display fetch at cycle 10
    host_req(1'b1, 15'h0123, 12'hF0A);
    step();
    while (cyc < 10) step();
    d_dreq = 1'b1; d_daddr = 15'h0123;
    step();
    d_dreq = 1'b0;
    repeat (4) step();

    // Host write then read back
    host_req(1'b1, 15'h0040, 12'h5A5);
    step();
    repeat (2) step();
    host_req(1'b0, 15'h0040, '0);
    step();
    repeat (4) step();

    // Display and host read collide
    d_dreq = 1'b1; d_daddr = 15'h0123;
    host_req(1'b0, 15'h0040, '0);
    step();
    d_dreq = 1'b0;
    step();
    repeat (5) step();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      d_rst   = ($urandom_range(0, 399) == 0);
      d_dreq  = ($urandom_range(0, 2) == 0);
      d_daddr = AW'($urandom_range(0, 31));
      if ($urandom_range(0, 15) == 0) d_blank = ~d_blank;
      if ($urandom_range(0, 49) == 0) d_bonly = ~d_bonly;
      d_clr   = ($urandom_range(0, 99) == 0);
      if (!h_pend && $urandom_range(0, 1) == 1)
        host_req(1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), DW'($urandom));
      step();
    end
    d_rst = 1'b0; d_dreq = 1'b0; d_clr = 1'b0; d_bonly = 1'b0;
    while (h_pend) step();
    repeat (4) step();

    // Starvation under blank-only mode
    d_clr = 1'b1;
    step();
    d_clr = 1'b0;
    d_bonly = 1'b1; d_blank = 1'b0;
    host_req(1'b1, 15'h0007, 12'h321);
    repeat (1024) step();
    repeat (3) step();
    d_blank = 1'b1;
    step();
    d_blank = 1'b0;
    repeat (2) step();
    d_clr = 1'b1;
    step();
    d_clr = 1'b0;
    step();

    // Clear coincident with the set condition
    host_req(1'b0, 15'h0007, '0);
    repeat (1023) step();
    d_clr = 1'b1;
    step();
    d_clr = 1'b0;
    repeat (5) step();
    d_blank = 1'b1;
    step();
    d_bonly = 1'b0;
    repeat (4) step();

    // Reset right after two granted reads
    host_req(1'b0, 15'h0005, '0);
    step();
    host_req(1'b0, 15'h0006, '0);
    step();
    d_rst = 1'b1;
    step();
    d_rst = 1'b0;
    repeat (6) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
